// File: rtl/stopwatch_digits.sv
// stopwatch_digits: debounced start/stop/lap/clear stopwatch producing six BCD digits (MM:SS.cc)
module stopwatch_digits #(
  parameter int TICK_DIV = 500_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       START_STOP_N,
  input  logic       LAP_N,
  input  logic       CLEAR_N,
  output logic [3:0] DIGIT0,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT2,
  output logic [3:0] DIGIT3,
  output logic [3:0] DIGIT4,
  output logic [3:0] DIGIT5,
  output logic       RUNNING,
  output logic       LAP_HELD,
  output logic       TICK
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSED} state_t;
  state_t st, nxt;
  logic [2:0] raw, press;
  logic [PW-1:0] presc;
  logic [3:0] live [6];
  logic [3:0] live_n [6];
  logic [3:0] disp [6];
  logic start, lap, clr_go, cnt_en, adv, carry;
  assign raw = {CLEAR_N, LAP_N, START_STOP_N};
  for (genvar g = 0; g < 3; g++) begin : g_key
    logic s1, s2, acc, ev;
    logic [CW-1:0] cnt;
    always_ff @(posedge CLOCK or negedge RESET_N)
      if (!RESET_N) begin
        s1 <= 1'b1;
        s2 <= 1'b1;
        acc <= 1'b1;
        cnt <= '0;
        ev <= 1'b0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        ev <= 1'b0;
        if (s2 == acc) cnt <= '0;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          acc <= s2;
          cnt <= '0;
          ev <= ~s2;
        end else cnt <= cnt + 1'b1;
      end
    assign press[g] = ev;
  end
  function automatic logic [3:0] lim(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction
  assign start = press[0];
  assign lap = press[1];
  assign cnt_en = st == RUN || st == LAP;
  assign clr_go = st == PAUSED && press[2];
  assign adv = cnt_en && presc == PW'(TICK_DIV - 1);
  // priority clear > start > lap, each only where it is valid
  assign nxt = clr_go ? IDLE : start ? (cnt_en ? PAUSED : RUN) :
               (lap && st == RUN) ? LAP : (lap && st == LAP) ? RUN : st;
  always_comb begin
    carry = adv;
    for (int i = 0; i < 6; i++) begin
      live_n[i] = clr_go ? 4'd0 : !carry ? live[i] : live[i] == lim(i) ? 4'd0 : live[i] + 4'd1;
      carry = carry && live[i] == lim(i);
    end
  end
  // the display register doubles as the lap snapshot: it simply holds while in LAP
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      st <= IDLE;
      presc <= '0;
      RUNNING <= 1'b0;
      LAP_HELD <= 1'b0;
      TICK <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        live[i] <= '0;
        disp[i] <= '0;
      end
    end else begin
      st <= nxt;
      presc <= (clr_go || adv) ? '0 : cnt_en ? presc + 1'b1 : presc;
      for (int i = 0; i < 6; i++) begin
        live[i] <= live_n[i];
        disp[i] <= nxt == LAP ? disp[i] : live_n[i];
      end
      RUNNING <= nxt == RUN || nxt == LAP;
      LAP_HELD <= nxt == LAP;
      TICK <= adv;
    end
  assign DIGIT0 = disp[0];
  assign DIGIT1 = disp[1];
  assign DIGIT2 = disp[2];
  assign DIGIT3 = disp[3];
  assign DIGIT4 = disp[4];
  assign DIGIT5 = disp[5];
endmodule
